// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory request arbiter: FSM states, grant ids
// and the watchdog counter width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IFU = 1'b0,
        GNT_LSU = 1'b1
    } gnt_id_t;

    localparam int unsigned DEF_TIMEOUT_CYC = 1023;

    // A disabled watchdog (timeout 0) still gets a 1-bit counter so widths stay legal.
    function automatic int unsigned wdog_width(input int unsigned timeout_cyc);
        return (timeout_cyc == 0) ? 1 : $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Two-way IFU/LSU grant selection, combinational from the request valids.
// MEM_ARB_ROUNDROBIN_EN: alternate on contention; otherwise LSU has fixed priority.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    ifu_vld,
    input  logic    lsu_vld,
    input  logic    upd,
    input  gnt_id_t upd_id,
    output gnt_id_t gnt
);

`ifdef MEM_ARB_ROUNDROBIN_EN
    gnt_id_t last_grant;

    // Only a retired transaction counts as "granted last".
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GNT_IFU;
        end else if (upd) begin
            last_grant <= upd_id;
        end
    end

    always_comb begin
        gnt = GNT_IFU;
        if (ifu_vld && lsu_vld) begin
            gnt = (last_grant == GNT_IFU) ? GNT_LSU : GNT_IFU;
        end else if (lsu_vld) begin
            gnt = GNT_LSU;
        end
    end
`else
    logic unused_rr_inputs;
    assign unused_rr_inputs = ^{clk, rst, ifu_vld, upd, upd_id};

    assign gnt = lsu_vld ? GNT_LSU : GNT_IFU;
`endif

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates IFU/LSU onto one memory master port, one transaction in flight; accept->rsp_valid 3 cycles min.
// Requests wait in IDLE only; RESP holds until the owner's rsp_ready. Grant policy via MEM_ARB_ROUNDROBIN_EN.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW          = 64,
    parameter int unsigned DW          = 64,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_rsp_valid,
    input  logic            ifu_rsp_ready,
    output logic [DW-1:0]   ifu_data_r,
    output logic            ifu_rsp_err,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_addr,
    input  logic [DW-1:0]   lsu_data_w,
    input  logic [DW/8-1:0] lsu_wstrb,
    input  logic            lsu_wen,
    output logic            lsu_rsp_valid,
    input  logic            lsu_rsp_ready,
    output logic [DW-1:0]   lsu_data_r,
    output logic            lsu_rsp_err,
    output logic            mem_mstReq_valid,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_data_w,
    output logic [DW/8-1:0] mem_wstrb,
    output logic            mem_wen,
    input  logic [DW-1:0]   mem_data_r,
    input  logic            mem_slvRsp_valid,
    output logic            mem_mstRsp_ready
);

    localparam int unsigned      WDW       = wdog_width(TIMEOUT_CYC);
    localparam bit               WDOG_EN   = (TIMEOUT_CYC != 0);
    localparam logic [WDW-1:0]   WDOG_LAST = WDW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    arb_state_t      state;
    gnt_id_t         gnt;
    gnt_id_t         cur_id;
    logic [WDW-1:0]  wdog;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            cur_rsp_rdy;
    logic            retire;

    mem_arb_grant u_grant (
        .clk     (CLK),
        .rst     (RST),
        .ifu_vld (ifu_req_valid),
        .lsu_vld (lsu_req_valid),
        .upd     (retire),
        .upd_id  (cur_id),
        .gnt     (gnt)
    );

    assign ifu_req_ready = (state == ST_IDLE) && ifu_req_valid && (gnt == GNT_IFU);
    assign lsu_req_ready = (state == ST_IDLE) && lsu_req_valid && (gnt == GNT_LSU);

    assign cur_rsp_rdy = (cur_id == GNT_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
    assign retire      = (state == ST_RESP) && cur_rsp_rdy;

    // One shared response register, exposed only to the owning master.
    assign ifu_data_r  = ifu_rsp_valid ? rsp_data : '0;
    assign lsu_data_r  = lsu_rsp_valid ? rsp_data : '0;
    assign ifu_rsp_err = ifu_rsp_valid & rsp_err;
    assign lsu_rsp_err = lsu_rsp_valid & rsp_err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state            <= ST_IDLE;
            cur_id           <= GNT_IFU;
            wdog             <= '0;
            mem_mstReq_valid <= 1'b0;
            mem_mstRsp_ready <= 1'b0;
            mem_addr         <= '0;
            mem_data_w       <= '0;
            mem_wstrb        <= '0;
            mem_wen          <= 1'b0;
            ifu_rsp_valid    <= 1'b0;
            lsu_rsp_valid    <= 1'b0;
            rsp_data         <= '0;
            rsp_err          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ifu_req_valid || lsu_req_valid) begin
                        cur_id           <= gnt;
                        mem_mstReq_valid <= 1'b1;
                        state            <= ST_ISSUE;
                        if (gnt == GNT_LSU) begin
                            mem_addr   <= lsu_addr;
                            mem_data_w <= lsu_data_w;
                            mem_wstrb  <= lsu_wstrb;
                            mem_wen    <= lsu_wen;
                        end else begin
                            mem_addr   <= ifu_addr;
                            mem_data_w <= '0;
                            mem_wstrb  <= '0;
                            mem_wen    <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    mem_mstReq_valid <= 1'b0;
                    mem_mstRsp_ready <= 1'b1;
                    wdog             <= '0;
                    state            <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A response arriving on the expiry cycle still wins over the timeout.
                    if (mem_slvRsp_valid || (WDOG_EN && (wdog == WDOG_LAST))) begin
                        rsp_data         <= (mem_slvRsp_valid && !mem_wen) ? mem_data_r : '0;
                        rsp_err          <= !mem_slvRsp_valid;
                        mem_mstRsp_ready <= 1'b0;
                        ifu_rsp_valid    <= (cur_id == GNT_IFU);
                        lsu_rsp_valid    <= (cur_id == GNT_LSU);
                        state            <= ST_RESP;
                    end else if (WDOG_EN) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (cur_rsp_rdy) begin
                        ifu_rsp_valid <= 1'b0;
                        lsu_rsp_valid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
